// File: rtl/id_stage_pkg.sv
// Shared decode constants and ALU operation codes for the ID stage.
package id_stage_pkg;

   typedef enum logic [4:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ADDI, ALU_SLTI, ALU_SLTIU,
      ALU_XORI, ALU_ORI, ALU_ANDI, ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_LUI
   } alu_op_e;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_decode.sv
// Pure combinational RV32I integer-subset decode; anything unsupported comes out
// as NOP with no reads, no write and a zero immediate.
module id_decode
   import id_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic [31:0]        i_inst,
   output alu_op_e            o_alu_op,
   output logic               o_re1,
   output logic               o_re2,
   output logic [RADDR_W-1:0] o_raddr1,
   output logic [RADDR_W-1:0] o_raddr2,
   output logic               o_we,
   output logic [RADDR_W-1:0] o_waddr,
   output logic               o_use_imm,
   output logic [XLEN-1:0]    o_imm,
   output logic               o_illegal
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   alu_op_e    w_op;
   logic       w_re1, w_re2, w_use_imm, w_ok;
   logic [XLEN-1:0] w_imm;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];
   assign w_f7  = i_inst[31:25];

   always_comb begin
      w_op      = ALU_NOP;
      w_re1     = 1'b0;
      w_re2     = 1'b0;
      w_use_imm = 1'b0;
      w_imm     = '0;
      w_ok      = 1'b1;
      case (w_opc)
         OPC_OP_IMM: begin
            w_re1     = 1'b1;
            w_use_imm = 1'b1;
            w_imm     = XLEN'($signed(i_inst[31:20]));
            case (w_f3)
               F3_ADD:  w_op = ALU_ADDI;
               F3_SLT:  w_op = ALU_SLTI;
               F3_SLTU: w_op = ALU_SLTIU;
               F3_XOR:  w_op = ALU_XORI;
               F3_OR:   w_op = ALU_ORI;
               F3_AND:  w_op = ALU_ANDI;
               F3_SLL: begin
                  w_imm = XLEN'(i_inst[24:20]);
                  if (w_f7 == F7_BASE) w_op = ALU_SLLI;
                  else                 w_ok = 1'b0;
               end
               F3_SR: begin
                  // shift amount only; the funct7 bits select logical/arithmetic
                  w_imm = XLEN'(i_inst[24:20]);
                  if (w_f7 == F7_BASE)     w_op = ALU_SRLI;
                  else if (w_f7 == F7_ALT) w_op = ALU_SRAI;
                  else                     w_ok = 1'b0;
               end
               default: w_ok = 1'b0;
            endcase
         end
         OPC_OP: begin
            w_re1 = 1'b1;
            w_re2 = 1'b1;
            if (w_f7 == F7_BASE) begin
               case (w_f3)
                  F3_ADD:  w_op = ALU_ADD;
                  F3_SLL:  w_op = ALU_SLL;
                  F3_SLT:  w_op = ALU_SLT;
                  F3_SLTU: w_op = ALU_SLTU;
                  F3_XOR:  w_op = ALU_XOR;
                  F3_SR:   w_op = ALU_SRL;
                  F3_OR:   w_op = ALU_OR;
                  F3_AND:  w_op = ALU_AND;
                  default: w_ok = 1'b0;
               endcase
            end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
               w_op = ALU_SUB;
            end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
               w_op = ALU_SRA;
            end else begin
               w_ok = 1'b0;
            end
         end
         OPC_LUI: begin
            w_use_imm = 1'b1;
            w_imm     = XLEN'($signed({i_inst[31:12], 12'b0}));
            w_op      = ALU_LUI;
         end
         default: w_ok = 1'b0;
      endcase
      if (!w_ok) begin
         w_op      = ALU_NOP;
         w_re1     = 1'b0;
         w_re2     = 1'b0;
         w_use_imm = 1'b0;
         w_imm     = '0;
      end
   end

   assign o_alu_op  = w_op;
   assign o_re1     = w_re1;
   assign o_re2     = w_re2;
   assign o_raddr1  = w_re1 ? RADDR_W'(i_inst[19:15]) : '0;
   assign o_raddr2  = w_re2 ? RADDR_W'(i_inst[24:20]) : '0;
   assign o_we      = w_ok;
   assign o_waddr   = w_ok ? RADDR_W'(i_inst[11:7]) : '0;
   assign o_use_imm = w_use_imm;
   assign o_imm     = w_imm;
   assign o_illegal = !w_ok;

endmodule

// File: rtl/id_stage.sv
// Decode stage: operand fetch with EXE/MEM forwarding, load-use stall and a
// single valid/ready output register (1-cycle latency, holds under backpressure).
module id_stage
   import id_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int FWD_EN  = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [XLEN-1:0]    inst_addr_i,
   input  logic [31:0]        inst_i,
   output logic [RADDR_W-1:0] reg1_raddr_o,
   output logic [RADDR_W-1:0] reg2_raddr_o,
   output logic               reg1_re_o,
   output logic               reg2_re_o,
   input  logic [XLEN-1:0]    reg1_rdata_i,
   input  logic [XLEN-1:0]    reg2_rdata_i,
   input  logic               exe_we_i,
   input  logic               exe_is_load_i,
   input  logic [RADDR_W-1:0] exe_waddr_i,
   input  logic [XLEN-1:0]    exe_wdata_i,
   input  logic               mem_we_i,
   input  logic [RADDR_W-1:0] mem_waddr_i,
   input  logic [XLEN-1:0]    mem_wdata_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output alu_op_e            aluOp_o,
   output logic [XLEN-1:0]    op1_o,
   output logic [XLEN-1:0]    op2_o,
   output logic               reg_we_o,
   output logic [RADDR_W-1:0] reg_waddr_o,
   output logic [XLEN-1:0]    inst_addr_o,
   output logic               illegal_o
);

   localparam bit L_FWD = (FWD_EN != 0);

   alu_op_e              w_op;
   logic                 w_re1, w_re2, w_we, w_use_imm, w_illegal;
   logic [RADDR_W-1:0]   w_raddr1, w_raddr2, w_waddr;
   logic [XLEN-1:0]      w_imm, w_src1, w_src2, w_op2;
   logic                 w_exe1, w_exe2, w_mem1, w_mem2, w_stall, w_adv, w_accept;

   logic                 r_valid, r_we, r_illegal;
   alu_op_e              r_op;
   logic [XLEN-1:0]      r_op1, r_op2, r_pc;
   logic [RADDR_W-1:0]   r_waddr;

   id_decode #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_dec (
      .i_inst    (inst_i),
      .o_alu_op  (w_op),
      .o_re1     (w_re1),
      .o_re2     (w_re2),
      .o_raddr1  (w_raddr1),
      .o_raddr2  (w_raddr2),
      .o_we      (w_we),
      .o_waddr   (w_waddr),
      .o_use_imm (w_use_imm),
      .o_imm     (w_imm),
      .o_illegal (w_illegal)
   );

   // Unused source addresses are already 0, so a nonzero match implies the read is enabled.
   assign w_exe1 = exe_we_i && exe_waddr_i == w_raddr1 && w_raddr1 != '0;
   assign w_exe2 = exe_we_i && exe_waddr_i == w_raddr2 && w_raddr2 != '0;
   assign w_mem1 = mem_we_i && mem_waddr_i == w_raddr1 && w_raddr1 != '0;
   assign w_mem2 = mem_we_i && mem_waddr_i == w_raddr2 && w_raddr2 != '0;

   assign w_stall = L_FWD ? (exe_is_load_i && (w_exe1 || w_exe2))
                          : (w_exe1 || w_exe2 || w_mem1 || w_mem2);

   assign w_src1 = (L_FWD && w_exe1 && !exe_is_load_i) ? exe_wdata_i :
                   (L_FWD && w_mem1)                   ? mem_wdata_i :
                   (w_raddr1 != '0)                    ? reg1_rdata_i : '0;
   assign w_src2 = (L_FWD && w_exe2 && !exe_is_load_i) ? exe_wdata_i :
                   (L_FWD && w_mem2)                   ? mem_wdata_i :
                   (w_raddr2 != '0)                    ? reg2_rdata_i : '0;
   assign w_op2  = w_use_imm ? w_imm : w_src2;

   assign w_adv      = !r_valid || out_ready_i;
   assign in_ready_o = w_adv && !w_stall && !flush_i;
   assign w_accept   = in_valid_i && in_ready_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid   <= 1'b0;
         r_illegal <= 1'b0;
         r_op      <= ALU_NOP;
         r_op1     <= '0;
         r_op2     <= '0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_pc      <= '0;
      end else begin
         // illegal is a first-presentation pulse, so it never survives a hold cycle
         r_illegal <= w_accept && w_illegal;
         if (flush_i) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_op    <= w_op;
            r_op1   <= w_src1;
            r_op2   <= w_op2;
            r_we    <= w_we;
            r_waddr <= w_waddr;
            r_pc    <= inst_addr_i;
         end else if (w_adv) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign reg1_raddr_o = w_raddr1;
   assign reg2_raddr_o = w_raddr2;
   assign reg1_re_o    = w_re1;
   assign reg2_re_o    = w_re2;
   assign out_valid_o  = r_valid;
   assign aluOp_o      = r_op;
   assign op1_o        = r_op1;
   assign op2_o        = r_op2;
   assign reg_we_o     = r_we;
   assign reg_waddr_o  = r_waddr;
   assign inst_addr_o  = r_pc;
   assign illegal_o    = r_illegal;

endmodule
